// File: rtl/pc_sequencer_pkg.sv
// Shared types and encodings for the PC sequencer and its next-PC selector.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_HALTED  = 2'd2
  } seq_state_t;

  // Must stay in step with the control unit's Jump encoding.
  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_ABS = 2'b01;
  localparam logic [1:0] JUMP_REG = 2'b10;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: taken branch, absolute jump, register jump, or pc+1.
module next_pc_logic
  import pc_sequencer_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [1:0]          jump,
  input  logic                branch,
  input  logic                alu_zero,
  input  logic [25:0]         jump_target,
  input  logic [15:0]         branch_offset,
  input  logic [31:0]         jr_addr,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic signed [PC_WIDTH-1:0] off_w;
  logic                       unused_hi;

  // Sign-extend (or truncate) the word offset to PC width; the sum wraps mod 2^PC_WIDTH.
  assign off_w     = PC_WIDTH'(signed'(branch_offset));
  assign pc_plus1  = pc + PC_WIDTH'(1);
  assign unused_hi = ^{jump_target[25:PC_WIDTH], jr_addr[31:PC_WIDTH]};

  always_comb begin
    next_pc = pc_plus1;
    if (branch && alu_zero) begin
      next_pc = pc_plus1 + off_w;
    end else begin
      case (jump)
        JUMP_ABS: next_pc = jump_target[PC_WIDTH-1:0];
        JUMP_REG: next_pc = jr_addr[PC_WIDTH-1:0];
        default:  next_pc = pc_plus1;
      endcase
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC register and RUN/WAIT_IN/HALTED sequencing with commit strobe, display latch and retire counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          Jump,
  input  logic                Branch,
  input  logic                alu_zero,
  input  logic                halt,
  input  logic                input_flag,
  input  logic                output_flag,
  input  logic [25:0]         jump_target,
  input  logic [15:0]         branch_offset,
  input  logic [31:0]         jr_addr,
  input  logic                in_valid,
  input  logic [31:0]         out_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1,
  output logic                commit,
  output logic                halted,
  output logic [31:0]         display,
  output logic                out_strobe,
  output logic [31:0]         retired
);

  seq_state_t          state, state_nxt;
  logic [PC_WIDTH-1:0] next_pc;

  next_pc_logic #(.PC_WIDTH(PC_WIDTH)) u_next_pc (
    .pc            (pc),
    .jump          (Jump),
    .branch        (Branch),
    .alu_zero      (alu_zero),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .jr_addr       (jr_addr),
    .pc_plus1      (pc_plus1),
    .next_pc       (next_pc)
  );

  assign halted = (state == ST_HALTED);

  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_RUN: begin
        if (halt) begin
          state_nxt = ST_HALTED;
        end else if (input_flag && !in_valid) begin
          state_nxt = ST_WAIT_IN;
        end else begin
          commit = 1'b1;
        end
      end
      ST_WAIT_IN: begin
        if (in_valid) begin
          commit    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RUN;
    endcase
    // No architectural write may slip through on a reset edge.
    if (!reset) begin
      commit = 1'b0;
    end
  end

  // Registered state: PC, FSM, display latch, strobe and retire count.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      display    <= '0;
      out_strobe <= 1'b0;
      retired    <= '0;
    end else begin
      state      <= state_nxt;
      out_strobe <= commit && output_flag;
      if (commit) begin
        pc      <= next_pc;
        retired <= retired + 32'd1;
        if (output_flag) begin
          display <= out_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  Jump;
  logic        Branch, alu_zero, halt, input_flag, output_flag, in_valid;
  logic [25:0] jump_target;
  logic [15:0] branch_offset;
  logic [31:0] jr_addr, out_data;
  logic [9:0]  pc, pc_plus1;
  logic        commit, halted, out_strobe;
  logic [31:0] display, retired;

  typedef struct {
    logic [9:0]  pc;
    logic        commit;
    logic        halted;
    logic [31:0] ret;
    logic [31:0] disp;
    logic        strobe;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  pc_sequencer #(.PC_WIDTH(10), .RESET_PC(10'd0)) dut (
    .clock         (clock),
    .reset         (reset),
    .Jump          (Jump),
    .Branch        (Branch),
    .alu_zero      (alu_zero),
    .halt          (halt),
    .input_flag    (input_flag),
    .output_flag   (output_flag),
    .jump_target   (jump_target),
    .branch_offset (branch_offset),
    .jr_addr       (jr_addr),
    .in_valid      (in_valid),
    .out_data      (out_data),
    .pc            (pc),
    .pc_plus1      (pc_plus1),
    .commit        (commit),
    .halted        (halted),
    .display       (display),
    .out_strobe    (out_strobe),
    .retired       (retired)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per driven cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [9:0] p1;
      e  = q.pop_front();
      p1 = e.pc + 10'd1;
      chk("pc",         32'(pc),         32'(e.pc));
      chk("pc_plus1",   32'(pc_plus1),   32'(p1));
      chk("commit",     32'(commit),     32'(e.commit));
      chk("halted",     32'(halted),     32'(e.halted));
      chk("retired",    retired,         e.ret);
      chk("display",    display,         e.disp);
      chk("out_strobe", 32'(out_strobe), 32'(e.strobe));
    end
  end

  task automatic v(input logic rst, input logic [1:0] jmp, input logic br, input logic z,
                   input logic hlt, input logic inf, input logic outf, input logic [25:0] jt,
                   input logic [15:0] off, input logic [31:0] jra, input logic iv, input logic [31:0] od,
                   input logic [9:0] epc, input logic ecm, input logic ehl, input logic [31:0] eret,
                   input logic [31:0] edisp, input logic estb);
    exp_t e;
    reset = rst; Jump = jmp; Branch = br; alu_zero = z; halt = hlt; input_flag = inf;
    output_flag = outf; jump_target = jt; branch_offset = off; jr_addr = jra; in_valid = iv; out_data = od;
    e.pc = epc; e.commit = ecm; e.halted = ehl; e.ret = eret; e.disp = edisp; e.strobe = estb;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; Jump = 2'b00; Branch = 1'b0; alu_zero = 1'b0; halt = 1'b0;
    input_flag = 1'b0; output_flag = 1'b0; jump_target = '0; branch_offset = '0;
    jr_addr = '0; in_valid = 1'b0; out_data = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    // rst jmp br z hlt inf outf jt off jra iv od | pc commit halted retired display strobe
    v(1, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd0,   1, 0, 0,  32'h0,        0);
    v(1, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd1,   1, 0, 1,  32'h0,        0);
    v(1, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd2,   1, 0, 2,  32'h0,        0);
    v(1, 1, 0, 0, 0, 0, 0, 26'd5,        16'h0000, 32'h0,         0, 32'h0,         10'd3,   1, 0, 3,  32'h0,        0);
    v(1, 0, 1, 1, 0, 0, 0, 26'd0,        16'hFFFD, 32'h0,         0, 32'h0,         10'd5,   1, 0, 4,  32'h0,        0);
    v(1, 1, 0, 0, 0, 0, 0, 26'd5,        16'h0000, 32'h0,         0, 32'h0,         10'd3,   1, 0, 5,  32'h0,        0);
    v(1, 0, 1, 0, 0, 0, 0, 26'd0,        16'hFFFD, 32'h0,         0, 32'h0,         10'd5,   1, 0, 6,  32'h0,        0);
    v(1, 1, 1, 1, 0, 0, 0, 26'd100,      16'h0002, 32'h0,         0, 32'h0,         10'd6,   1, 0, 7,  32'h0,        0);
    v(1, 1, 0, 0, 0, 0, 0, 26'h3FFFFFF,  16'h0000, 32'h0,         0, 32'h0,         10'd9,   1, 0, 8,  32'h0,        0);
    v(1, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'h3FF, 1, 0, 9,  32'h0,        0);
    v(1, 2, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'hFFFFF007,  0, 32'h0,         10'd0,   1, 0, 10, 32'h0,        0);
    v(1, 0, 0, 0, 0, 1, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd7,   0, 0, 11, 32'h0,        0);
    for (int i = 0; i < 3; i++)
      v(1, 0, 0, 0, 0, 1, 0, 26'd0,      16'h0000, 32'h0,         0, 32'h0,         10'd7,   0, 0, 11, 32'h0,        0);
    v(1, 0, 0, 0, 0, 1, 0, 26'd0,        16'h0000, 32'h0,         1, 32'h0,         10'd7,   1, 0, 11, 32'h0,        0);
    v(1, 0, 0, 0, 0, 0, 1, 26'd0,        16'h0000, 32'h0,         1, 32'hDEADBEEF,  10'd8,   1, 0, 12, 32'h0,        0);
    v(1, 0, 0, 0, 1, 0, 1, 26'd0,        16'h0000, 32'h0,         0, 32'h12345678,  10'd9,   0, 0, 13, 32'hDEADBEEF, 1);
    for (int i = 0; i < 10; i++)
      v(1, 1, 0, 0, 0, 1, 1, 26'd55,     16'h0000, 32'h0,         1, 32'h0BADF00D,  10'd9,   0, 1, 13, 32'hDEADBEEF, 0);
    v(0, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd9,   0, 1, 13, 32'hDEADBEEF, 0);
    v(1, 0, 0, 0, 0, 1, 0, 26'd0,        16'h0000, 32'h0,         1, 32'h0,         10'd0,   1, 0, 0,  32'h0,        0);
    v(1, 0, 0, 0, 1, 1, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd1,   0, 0, 1,  32'h0,        0);
    v(0, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd1,   0, 1, 1,  32'h0,        0);
    v(1, 0, 0, 0, 0, 1, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd0,   0, 0, 0,  32'h0,        0);
    v(0, 0, 0, 0, 0, 1, 0, 26'd0,        16'h0000, 32'h0,         1, 32'h0,         10'd0,   0, 0, 0,  32'h0,        0);
    v(1, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd0,   1, 0, 0,  32'h0,        0);
    v(1, 0, 0, 0, 0, 0, 0, 26'd0,        16'h0000, 32'h0,         0, 32'h0,         10'd1,   1, 0, 1,  32'h0,        0);
    @(negedge clock);
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
